// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register-file write port (ALU vs load) with a pending-load scoreboard.
// Optional macro REGARB_BYPASS_EN adds a write-stage bypass and drops the write-stage term from the hazards.
module regfile_write_arbiter #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]   alu_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_rd,
   input  logic [XLEN-1:0]   mem_data,
   input  logic              reserve_valid,
   input  logic [ADDR_W-1:0] reserve_rd,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   output logic              hazard1,
   output logic              hazard2,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_rd,
   output logic [XLEN-1:0]   wr_data,
   output logic              fwd1_valid,
   output logic              fwd2_valid,
   output logic [XLEN-1:0]   fwd1_data,
   output logic [XLEN-1:0]   fwd2_data
);

   localparam int NREG = 2 ** ADDR_W;

   logic              r_last_mem;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_rd;
   logic [XLEN-1:0]   r_wr_data;
   logic [NREG-1:0]   r_pend;

   logic              w_alu_grant;
   logic              w_mem_grant;
   logic              w_grant;
   logic [ADDR_W-1:0] w_rd;
   logic [XLEN-1:0]   w_data;
   logic [NREG-1:0]   w_set;
   logic [NREG-1:0]   w_clr;
   logic              w_hit1;
   logic              w_hit2;

   // A contested cycle goes to whichever source did not win last time.
   always_comb begin
      w_alu_grant = alu_valid && (!mem_valid || r_last_mem);
      w_mem_grant = mem_valid && (!alu_valid || !r_last_mem);
      w_grant     = w_alu_grant || w_mem_grant;
      w_rd        = w_mem_grant ? mem_rd : alu_rd;
      w_data      = w_mem_grant ? mem_data : alu_data;
   end

   assign alu_ready = w_alu_grant;
   assign mem_ready = w_mem_grant;

   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (reserve_valid && (reserve_rd != '0))
         w_set[reserve_rd] = 1'b1;
      if (w_mem_grant)
         w_clr[mem_rd] = 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_last_mem <= 1'b1;
         r_wr_en    <= 1'b0;
         r_wr_rd    <= '0;
         r_wr_data  <= '0;
         r_pend     <= '0;
      end else begin
         if (w_grant) begin
            r_last_mem <= w_mem_grant;
            r_wr_rd    <= w_rd;
            r_wr_data  <= w_data;
         end
         // Writes to x0 are consumed but never reach the register file.
         r_wr_en <= w_grant && (w_rd != '0);
         r_pend  <= (r_pend & ~w_clr) | w_set;
      end
   end

   assign wr_en   = r_wr_en;
   assign wr_rd   = r_wr_rd;
   assign wr_data = r_wr_data;

   assign w_hit1 = r_wr_en && (r_wr_rd == rs1) && (rs1 != '0);
   assign w_hit2 = r_wr_en && (r_wr_rd == rs2) && (rs2 != '0);

`ifdef REGARB_BYPASS_EN
   assign hazard1    = r_pend[rs1];
   assign hazard2    = r_pend[rs2];
   assign fwd1_valid = w_hit1;
   assign fwd2_valid = w_hit2;
   assign fwd1_data  = r_wr_data;
   assign fwd2_data  = r_wr_data;
`else
   // Without bypass the in-flight write must also stall decode for a cycle.
   assign hazard1    = r_pend[rs1] || w_hit1;
   assign hazard2    = r_pend[rs2] || w_hit2;
   assign fwd1_valid = 1'b0;
   assign fwd2_valid = 1'b0;
   assign fwd1_data  = '0;
   assign fwd2_data  = '0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed-vector bench for regfile_write_arbiter; expectations follow REGARB_BYPASS_EN when defined.
module tb_regfile_write_arbiter;

   localparam int XLEN   = 32;
   localparam int ADDR_W = 5;

   logic              clock = 1'b0;
   logic              reset;
   logic              alu_valid, mem_valid, reserve_valid;
   logic              alu_ready, mem_ready;
   logic [ADDR_W-1:0] alu_rd, mem_rd, reserve_rd, rs1, rs2;
   logic [XLEN-1:0]   alu_data, mem_data;
   logic              hazard1, hazard2, wr_en;
   logic [ADDR_W-1:0] wr_rd;
   logic [XLEN-1:0]   wr_data;
   logic              fwd1_valid, fwd2_valid;
   logic [XLEN-1:0]   fwd1_data, fwd2_data;

   int n_vec = 0;
   int n_err = 0;

   regfile_write_arbiter #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
      .clock(clock), .reset(reset),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .reserve_valid(reserve_valid), .reserve_rd(reserve_rd),
      .rs1(rs1), .rs2(rs2), .hazard1(hazard1), .hazard2(hazard2),
      .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data),
      .fwd1_valid(fwd1_valid), .fwd2_valid(fwd2_valid),
      .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
   );

   always #5 clock = ~clock;

   task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      alu_valid = 0; mem_valid = 0; reserve_valid = 0;
      alu_rd = 0; mem_rd = 0; reserve_rd = 0; rs1 = 0; rs2 = 0;
      alu_data = 0; mem_data = 0;
      tick();
      chk_vec("rst_wr_en", wr_en, 0);
      chk_vec("rst_wr_rd", wr_rd, 0);
      chk_vec("rst_wr_data", wr_data, 0);
      chk_vec("rst_hazard1", hazard1, 0);
      chk_vec("rst_fwd1", fwd1_valid, 0);
      reset = 1'b0;
      tick();

      // Single ALU write
      alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
      #1;
      chk_vec("alu_ready", alu_ready, 1);
      chk_vec("alu_mem_ready", mem_ready, 0);
      tick();
      alu_valid = 0;
      chk_vec("alu_wr_en", wr_en, 1);
      chk_vec("alu_wr_rd", wr_rd, 5);
      chk_vec("alu_wr_data", wr_data, 32'hDEADBEEF);
      tick();
      chk_vec("alu_wr_en_off", wr_en, 0);
      chk_vec("alu_wr_rd_hold", wr_rd, 5);

      // Fresh reset, then continuous contention
      reset = 1'b1;
      #1;
      reset = 1'b0;
      tick();
      alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
      mem_valid = 1; mem_rd = 2; mem_data = 32'h22;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk_vec($sformatf("rr_alu_ready%0d", i), alu_ready, (i % 2 == 0) ? 1 : 0);
         chk_vec($sformatf("rr_mem_ready%0d", i), mem_ready, (i % 2 == 1) ? 1 : 0);
         tick();
         chk_vec($sformatf("rr_wr_rd%0d", i), wr_rd, (i % 2 == 0) ? 1 : 2);
         chk_vec($sformatf("rr_wr_data%0d", i), wr_data, (i % 2 == 0) ? 32'h11 : 32'h22);
         chk_vec($sformatf("rr_wr_en%0d", i), wr_en, 1);
      end
      alu_valid = 0; mem_valid = 0;

      // Scoreboard set and clear on rd 7
      reserve_valid = 1; reserve_rd = 7; rs1 = 7;
      #1;
      chk_vec("sb_pre_hazard", hazard1, 0);
      tick();
      reserve_valid = 0;
      chk_vec("sb_set_hazard", hazard1, 1);
      tick();
      chk_vec("sb_hold_hazard", hazard1, 1);
      mem_valid = 1; mem_rd = 7; mem_data = 32'h77;
      #1;
      chk_vec("sb_mem_ready", mem_ready, 1);
      chk_vec("sb_grant_hazard", hazard1, 1);
      tick();
      mem_valid = 0;
      chk_vec("sb_wr_rd", wr_rd, 7);
`ifdef REGARB_BYPASS_EN
      chk_vec("sb_wr_hazard", hazard1, 0);
      chk_vec("sb_fwd_valid", fwd1_valid, 1);
      chk_vec("sb_fwd_data", fwd1_data, 32'h77);
`else
      chk_vec("sb_wr_hazard", hazard1, 1);
      chk_vec("sb_fwd_valid", fwd1_valid, 0);
`endif
      tick();
      chk_vec("sb_clear_hazard", hazard1, 0);
      chk_vec("sb_clear_wr_en", wr_en, 0);

      // Register 0: consumed but never written or reserved
      alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
      reserve_valid = 1; reserve_rd = 0; rs1 = 0;
      #1;
      chk_vec("x0_alu_ready", alu_ready, 1);
      tick();
      alu_valid = 0; reserve_valid = 0;
      chk_vec("x0_wr_en", wr_en, 0);
      chk_vec("x0_hazard1", hazard1, 0);
      tick();
      chk_vec("x0_hazard1_late", hazard1, 0);

      // Same-cycle reserve and clear of rd 9: reserve wins
      mem_valid = 1; mem_rd = 9; mem_data = 32'h99;
      reserve_valid = 1; reserve_rd = 9; rs2 = 9;
      #1;
      chk_vec("sc_mem_ready", mem_ready, 1);
      tick();
      mem_valid = 0; reserve_valid = 0;
      chk_vec("sc_hazard2", hazard2, 1);
      tick();
      chk_vec("sc_hazard2_pend", hazard2, 1);
      chk_vec("sc_wr_en_off", wr_en, 0);

      // Asynchronous reset with a write in flight
      alu_valid = 1; alu_rd = 3; alu_data = 32'h33; rs1 = 3;
      tick();
      alu_valid = 0;
      chk_vec("ar_wr_en", wr_en, 1);
`ifdef REGARB_BYPASS_EN
      chk_vec("ar_fwd_valid", fwd1_valid, 1);
      chk_vec("ar_fwd_data", fwd1_data, 32'h33);
      chk_vec("ar_hazard1", hazard1, 0);
`else
      chk_vec("ar_hazard1", hazard1, 1);
`endif
      #1;
      reset = 1'b1;
      #1;
      chk_vec("ar_wr_en_cleared", wr_en, 0);
      chk_vec("ar_hazard1_cleared", hazard1, 0);
      chk_vec("ar_hazard2_cleared", hazard2, 0);
      chk_vec("ar_fwd_cleared", fwd1_valid, 0);
      chk_vec("ar_wr_data_cleared", wr_data, 0);
      reset = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
